// File: rtl/hex_scan_controller_if.sv
// Write bus from the board logic plus the scanned display outputs of
// hex_scan_controller. The board logic is the master, the controller the slave.
interface hex_scan_controller_if #(
   parameter int NUM_DIGITS = 6
);
   logic                      wr_en;
   logic [2:0]                wr_addr;
   logic [3:0]                wr_data;
   logic                      wr_blank;
   logic [7*NUM_DIGITS-1:0]   seg_out;
   logic [2:0]                scan_idx;
   logic                      frame_done;

   modport master (
      output wr_en, wr_addr, wr_data, wr_blank,
      input  seg_out, scan_idx, frame_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_blank,
      output seg_out, scan_idx, frame_done
   );
endinterface

// File: rtl/hex_scan_controller.sv
// hex_scan_controller: one shared hex decoder scanned across NUM_DIGITS
// seven-segment displays. Each digit holds a 4-bit value and a blank flag.
// A paced pointer decodes one digit per scan slot and latches the pattern
// into that digit's output register.
module hex_scan_controller #(
   parameter int NUM_DIGITS = 6,
   parameter int SCAN_DIV   = 4
) (
   input  logic                  Clock,
   input  logic                  Resetn,
   hex_scan_controller_if.slave  bus
);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   // Segment encoding: bit j is segment j (a = bit 0 .. g = bit 6), 1 = lit.
   function automatic logic [6:0] hex_decoder(input logic [3:0] v);
      logic [6:0] seg;
      case (v)
         4'h0:    seg = 7'b0111111;
         4'h1:    seg = 7'b0000110;
         4'h2:    seg = 7'b1011011;
         4'h3:    seg = 7'b1001111;
         4'h4:    seg = 7'b1100110;
         4'h5:    seg = 7'b1101101;
         4'h6:    seg = 7'b1111101;
         4'h7:    seg = 7'b0000111;
         4'h8:    seg = 7'b1111111;
         4'h9:    seg = 7'b1101111;
         4'hA:    seg = 7'b1110111;
         4'hB:    seg = 7'b1111100;
         4'hC:    seg = 7'b0111001;
         4'hD:    seg = 7'b1011110;
         4'hE:    seg = 7'b1111001;
         4'hF:    seg = 7'b1110001;
         default: seg = 7'b0000000;
      endcase
      return seg;
   endfunction

   logic [NUM_DIGITS-1:0][3:0] val_q, val_d;
   logic [NUM_DIGITS-1:0]      blank_q, blank_d;
   logic [NUM_DIGITS-1:0][6:0] seg_q, seg_d;
   logic [DIV_W-1:0]           div_q, div_d;
   logic [2:0]                 scan_idx_q, scan_idx_d;
   logic                       frame_done_q, frame_done_d;

   logic                       capture_s;
   logic                       last_digit_s;
   logic                       wr_legal_s;
   logic [IDX_W-1:0]           wr_idx_s;
   logic [IDX_W-1:0]           cur_idx_s;
   logic [6:0]                 dec_s;

   assign capture_s    = (div_q == DIV_W'(SCAN_DIV - 1));
   assign last_digit_s = (scan_idx_q == 3'(NUM_DIGITS - 1));
   assign wr_legal_s   = bus.wr_en && (int'(bus.wr_addr) < NUM_DIGITS);
   assign wr_idx_s     = bus.wr_addr[IDX_W-1:0];
   assign cur_idx_s    = scan_idx_q[IDX_W-1:0];

   // Next-state: digit writes, pacing counter, scan pointer and capture.
   // The capture reads pre-edge storage, so a same-edge write to the digit
   // being captured only shows up one frame later.
   always_comb begin
      val_d        = val_q;
      blank_d      = blank_q;
      seg_d        = seg_q;
      div_d        = div_q;
      scan_idx_d   = scan_idx_q;
      frame_done_d = 1'b0;
      dec_s        = blank_q[cur_idx_s] ? 7'b0000000 : hex_decoder(val_q[cur_idx_s]);

      if (wr_legal_s) begin
         val_d[wr_idx_s]   = bus.wr_data;
         blank_d[wr_idx_s] = bus.wr_blank;
      end else begin
         val_d   = val_q;
         blank_d = blank_q;
      end

      if (capture_s) begin
         div_d            = '0;
         seg_d[cur_idx_s] = dec_s;
         frame_done_d     = last_digit_s;
         if (last_digit_s) begin
            scan_idx_d = 3'd0;
         end else begin
            scan_idx_d = scan_idx_q + 3'd1;
         end
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   // State registers; reset blanks every digit and restarts the scan.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         val_q        <= '0;
         blank_q      <= '1;
         seg_q        <= '0;
         div_q        <= '0;
         scan_idx_q   <= 3'd0;
         frame_done_q <= 1'b0;
      end else begin
         val_q        <= val_d;
         blank_q      <= blank_d;
         seg_q        <= seg_d;
         div_q        <= div_d;
         scan_idx_q   <= scan_idx_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.seg_out    = seg_q;
   assign bus.scan_idx   = scan_idx_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_hex_scan_controller.sv
// Directed bench for hex_scan_controller: a 6-digit / SCAN_DIV=4 instance
// exercised with writes, and a 3-digit / SCAN_DIV=1 instance free-running
// alongside it on the same clock and reset.
module tb_hex_scan_controller;
   logic clk = 1'b0;
   logic rst_n = 1'b1;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int fd_cnt   = 0;

   logic [41:0] exp1, exp2, exp3, exp4;

   hex_scan_controller_if #(.NUM_DIGITS(6)) bus1 ();
   hex_scan_controller_if #(.NUM_DIGITS(3)) bus2 ();

   hex_scan_controller #(.NUM_DIGITS(6), .SCAN_DIV(4)) u_dut1 (
      .Clock  (clk),
      .Resetn (rst_n),
      .bus    (bus1.slave)
   );

   hex_scan_controller #(.NUM_DIGITS(3), .SCAN_DIV(1)) u_dut2 (
      .Clock  (clk),
      .Resetn (rst_n),
      .bus    (bus2.slave)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock edge, then check both scan pointers and frame pulses.
   // cyc counts edges since reset release.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      check("scan_idx1", 64'(bus1.scan_idx), 64'((cyc / 4) % 6));
      check("frame_done1", 64'(bus1.frame_done), 64'(cyc % 24 == 0));
      check("scan_idx2", 64'(bus2.scan_idx), 64'(cyc % 3));
      check("frame_done2", 64'(bus2.frame_done), 64'(cyc % 3 == 0));
      check("seg_out2", 64'(bus2.seg_out), 64'd0);
      if (bus1.frame_done) fd_cnt++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic b);
      bus1.wr_en    = 1'b1;
      bus1.wr_addr  = a;
      bus1.wr_data  = d;
      bus1.wr_blank = b;
      step();
      bus1.wr_en    = 1'b0;
   endtask

   task automatic blank_frame();
      for (int i = 0; i < 24; i++) begin
         step();
         check("seg_blank1", 64'(bus1.seg_out), 64'd0);
      end
   endtask

   task automatic check_reset_now(input string tag);
      check({tag, "_seg1"}, 64'(bus1.seg_out), 64'd0);
      check({tag, "_idx1"}, 64'(bus1.scan_idx), 64'd0);
      check({tag, "_fd1"}, 64'(bus1.frame_done), 64'd0);
      check({tag, "_idx2"}, 64'(bus2.scan_idx), 64'd0);
      check({tag, "_fd2"}, 64'(bus2.frame_done), 64'd0);
   endtask

   initial begin
      exp1 = '0;
      exp1[41:35] = 7'b1110001;   // digit 5 = F
      exp1[6:0]   = 7'b0000110;   // digit 0 = 1
      exp2 = exp1;
      exp2[20:14] = 7'b1110111;   // digit 2 = A
      exp3 = exp1;
      exp3[13:7]  = 7'b0111111;   // digit 1 = 0
      exp4 = exp1;
      exp4[13:7]  = 7'b1111111;   // digit 1 = 8

      bus1.wr_en = 1'b0; bus1.wr_addr = 3'd0; bus1.wr_data = 4'd0; bus1.wr_blank = 1'b0;
      bus2.wr_en = 1'b0; bus2.wr_addr = 3'd0; bus2.wr_data = 4'd0; bus2.wr_blank = 1'b0;

      // Power-on reset.
      #1 rst_n = 1'b0;
      #1 check_reset_now("por");
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc = 0;

      // Everything blanked: a whole frame of zeros.
      blank_frame();

      // Basic write and frame.
      fd_cnt = 0;
      wr(3'd0, 4'h1, 1'b0);
      wr(3'd5, 4'hF, 1'b0);
      run_to(48);
      check("basic_seg", 64'(bus1.seg_out), 64'(exp1));
      check("basic_fd_count", 64'(fd_cnt), 64'd1);

      // Illegal addresses are ignored.
      wr(3'd6, 4'h8, 1'b0);
      wr(3'd7, 4'h8, 1'b0);
      run_to(72);
      check("illegal_seg_f1", 64'(bus1.seg_out), 64'(exp1));
      run_to(96);
      check("illegal_seg_f2", 64'(bus1.seg_out), 64'(exp1));

      // Digit 2 shows A, then gets blanked at its next capture (edge 132).
      wr(3'd2, 4'hA, 1'b0);
      run_to(120);
      check("digit2_A", 64'(bus1.seg_out), 64'(exp2));
      wr(3'd2, 4'hA, 1'b1);
      run_to(131);
      check("blank_before_capture", 64'(bus1.seg_out), 64'(exp2));
      run_to(132);
      check("blank_after_capture", 64'(bus1.seg_out), 64'(exp1));
      run_to(144);

      // Write/capture collision on digit 1 (captured at edge 152).
      wr(3'd1, 4'h0, 1'b0);
      run_to(151);
      wr(3'd1, 4'h8, 1'b0);
      check("collision_old", 64'(bus1.seg_out), 64'(exp3));
      run_to(175);
      check("collision_hold", 64'(bus1.seg_out), 64'(exp3));
      run_to(176);
      check("collision_new", 64'(bus1.seg_out), 64'(exp4));
      run_to(178);

      // Mid-frame reset takes effect without a clock edge.
      rst_n = 1'b0;
      #2 check_reset_now("mid");
      @(posedge clk);
      #1 check_reset_now("mid_hold");
      rst_n = 1'b1;
      cyc = 0;
      blank_frame();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
